// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the RMII transmit state encoding.
package eth_pkg;

    localparam int RMII_REP_10M = 10;
    localparam int IFG_DEFAULT  = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2,
        IFG   = 2'd3
    } tx_state_e;

    // Width of an index over n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the oldest entry.
module sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = mem[rd_ptr_q];

endmodule

// File: rtl/rmii_tx_serializer.sv
// Buffers words and serialises them LSB-first onto an RMII-style transmit bus,
// with per-frame 10/100 slice repetition, underrun recovery and inter-frame gap.
module rmii_tx_serializer
    import eth_pkg::*;
#(
    parameter int IN_W       = 4,
    parameter int OUT_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int IFG_CYCLES = IFG_DEFAULT
) (
    input  logic             eth_rmii_clk,
    input  logic             rst_n,
    input  logic             speed_10m,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             eth_tx_dv,
    output logic [OUT_W-1:0] eth_tx_data,
    output logic             underrun,
    output logic             busy
);

    localparam int NSLICE = IN_W / OUT_W;
    localparam int SW     = clog2_min1(NSLICE);
    localparam int FW     = IN_W + 1;
    localparam int IFG_W  = $clog2(IFG_CYCLES * RMII_REP_10M + 1);

    localparam logic [SW-1:0]    SLICE_LAST   = SW'(NSLICE - 1);
    localparam logic [IFG_W-1:0] IFG_END_100M = IFG_W'(IFG_CYCLES - 1);
    localparam logic [IFG_W-1:0] IFG_END_10M  = IFG_W'(IFG_CYCLES * RMII_REP_10M - 1);

    tx_state_e        state_q, state_d;
    logic [FW-1:0]    word_q, word_d;
    logic [SW-1:0]    slice_q, slice_d;
    logic [3:0]       rep_cnt_q, rep_cnt_d;
    logic [3:0]       rep_q, rep_d;
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
    logic             uflag_q, uflag_d;
    logic             ready_en_q;

    logic             tx_dv_q, tx_dv_d;
    logic [OUT_W-1:0] tx_data_q, tx_data_d;
    logic             underrun_q, underrun_d;

    logic             fifo_wr;
    logic             fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_dout;

    logic [OUT_W-1:0] slices [NSLICE];
    logic [3:0]       frame_rep;
    logic             slot_end;
    logic             ifg_end;

    // in_ready is held low through reset and the first edge after it.
    assign in_ready = ready_en_q && !fifo_full;
    assign fifo_wr  = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (eth_rmii_clk),
        .rst_n (rst_n),
        .wr_en (fifo_wr),
        .rd_en (fifo_rd),
        .din   ({in_last, in_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign slices[gi] = word_q[gi*OUT_W +: OUT_W];
        end
    endgenerate

    assign frame_rep = speed_10m ? 4'(RMII_REP_10M) : 4'd1;
    assign slot_end  = (rep_cnt_q == rep_q - 4'd1);
    assign ifg_end   = (ifg_cnt_q == ((rep_q == 4'd1) ? IFG_END_100M : IFG_END_10M));

    always_ff @(posedge eth_rmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        slice_d   = slice_q;
        rep_cnt_d = rep_cnt_q;
        rep_d     = rep_q;
        ifg_cnt_d = ifg_cnt_q;
        uflag_d   = 1'b0;
        fifo_rd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = SEND;
                    fifo_rd   = 1'b1;
                    word_d    = fifo_dout;
                    slice_d   = '0;
                    rep_cnt_d = '0;
                    rep_d     = frame_rep;
                end
            end
            SEND: begin
                if (slot_end) begin
                    rep_cnt_d = '0;
                    slice_d   = (slice_q == SLICE_LAST) ? '0 : slice_q + SW'(1);
                    if (slice_q == SLICE_LAST) begin
                        if (word_q[IN_W]) begin
                            state_d   = IFG;
                            ifg_cnt_d = '0;
                        end else if (!fifo_empty) begin
                            fifo_rd = 1'b1;
                            word_d  = fifo_dout;
                        end else begin
                            state_d = FLUSH;
                            uflag_d = 1'b1;
                        end
                    end
                end else begin
                    rep_cnt_d = rep_cnt_q + 4'd1;
                end
            end
            FLUSH: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    if (fifo_dout[IN_W]) begin
                        state_d   = IFG;
                        ifg_cnt_d = '0;
                    end
                end
            end
            IFG: begin
                if (!ifg_end) begin
                    ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
                end else if (!fifo_empty) begin
                    // A queued frame starts straight away so busy never dips between frames.
                    state_d   = SEND;
                    fifo_rd   = 1'b1;
                    word_d    = fifo_dout;
                    slice_d   = '0;
                    rep_cnt_d = '0;
                    rep_d     = frame_rep;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs trail the state by one edge; underrun lines up with the dv drop.
    always_comb begin
        tx_dv_d    = (state_q == SEND);
        tx_data_d  = (state_q == SEND) ? slices[slice_q] : '0;
        underrun_d = uflag_q;
    end

    always_ff @(posedge eth_rmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            slice_q    <= '0;
            rep_cnt_q  <= '0;
            rep_q      <= 4'd1;
            ifg_cnt_q  <= '0;
            uflag_q    <= 1'b0;
            ready_en_q <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_data_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            word_q     <= word_d;
            slice_q    <= slice_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_q      <= rep_d;
            ifg_cnt_q  <= ifg_cnt_d;
            uflag_q    <= uflag_d;
            ready_en_q <= 1'b1;
            tx_dv_q    <= tx_dv_d;
            tx_data_q  <= tx_data_d;
            underrun_q <= underrun_d;
        end
    end

    assign eth_tx_dv   = tx_dv_q;
    assign eth_tx_data = tx_data_q;
    assign underrun    = underrun_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rmii_tx_serializer.sv
// Scoreboard bench for rmii_tx_serializer: directed frames, a slice monitor,
// and measurement of dv run lengths and inter-frame gaps.
module tb_rmii_tx_serializer;

    logic       eth_rmii_clk = 1'b0;
    logic       rst_n        = 1'b0;
    logic       speed_10m    = 1'b0;
    logic       in_valid     = 1'b0;
    logic [3:0] in_data      = 4'd0;
    logic       in_last      = 1'b0;
    logic       in_ready;
    logic       eth_tx_dv;
    logic [1:0] eth_tx_data;
    logic       underrun;
    logic       busy;

    always #5 eth_rmii_clk = ~eth_rmii_clk;

    rmii_tx_serializer dut (
        .eth_rmii_clk (eth_rmii_clk),
        .rst_n        (rst_n),
        .speed_10m    (speed_10m),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .eth_tx_dv    (eth_tx_dv),
        .eth_tx_data  (eth_tx_data),
        .underrun     (underrun),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int run_q[$];
    int gap_q[$];
    int under_cnt     = 0;
    int cyc           = 0;
    int first_dv_cyc  = -1;
    bit first_pending = 1'b0;
    bit saw_not_ready = 1'b0;
    int acc_cyc       = 0;
    int run_len       = 0;
    int low_len       = 0;
    bit after_frame   = 1'b0;

    always @(posedge eth_rmii_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every dv cycle and measures run/gap lengths.
    always @(negedge eth_rmii_clk) begin
        if (!rst_n) begin
            run_len     = 0;
            low_len     = 0;
            after_frame = 1'b0;
        end else begin
            if (eth_tx_dv) begin
                if (after_frame) begin
                    gap_q.push_back(low_len);
                    after_frame = 1'b0;
                    low_len     = 0;
                end
                if (first_pending) begin
                    first_dv_cyc  = cyc;
                    first_pending = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_slice", int'(eth_tx_data), -1);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    $display("slice t=%0t data=%0d exp=%0d", $time, eth_tx_data, e);
                    check("slice", int'(eth_tx_data), e);
                end
                run_len++;
            end else begin
                if (run_len > 0) begin
                    run_q.push_back(run_len);
                    run_len     = 0;
                    after_frame = 1'b1;
                    low_len     = 0;
                end
                if (after_frame) begin
                    low_len++;
                    if (!busy) begin
                        gap_q.push_back(low_len);
                        after_frame = 1'b0;
                        low_len     = 0;
                    end
                end
                check("idle_data", int'(eth_tx_data), 0);
            end
            if (underrun) begin
                under_cnt++;
                check("underrun_with_dv", int'(eth_tx_dv), 0);
            end
        end
    end

    task automatic push(input logic [3:0] d, input logic l, input bit expect_out, input int rep);
        int w;
        @(negedge eth_rmii_clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        w = 0;
        while (!in_ready && w < 2000) begin
            saw_not_ready = 1'b1;
            @(negedge eth_rmii_clk);
            w++;
        end
        check("push_accept", int'(w < 2000), 1);
        @(posedge eth_rmii_clk);
        acc_cyc = cyc;
        $display("push t=%0t data=0x%0h last=%0d", $time, d, l);
        if (expect_out) begin
            for (int s = 0; s < 2; s++) begin
                for (int r = 0; r < rep; r++) exp_q.push_back(int'((d >> (2*s)) & 4'h3));
            end
        end
    endtask

    task automatic idle_in();
        @(negedge eth_rmii_clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!busy && w < 50) begin @(negedge eth_rmii_clk); w++; end
        while (busy && w < 5000) begin @(negedge eth_rmii_clk); w++; end
        check("frame_done", int'(!busy), 1);
        repeat (2) @(negedge eth_rmii_clk);
    endtask

    task automatic check_shape(input int run_len_exp, input int gap_exp, input int nframes);
        check("run_count", run_q.size(), nframes);
        while (run_q.size() > 0) check("run_len", run_q.pop_front(), run_len_exp);
        check("gap_count", gap_q.size(), nframes);
        while (gap_q.size() > 0) check("gap_len", gap_q.pop_front(), gap_exp);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int cnt_dv;
        int cnt_busy;

        // Reset state
        repeat (3) @(negedge eth_rmii_clk);
        check("rst_dv", int'(eth_tx_dv), 0);
        check("rst_data", int'(eth_tx_data), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        @(posedge eth_rmii_clk);
        #1;
        check("ready_after_rst", int'(in_ready), 1);

        // 100M frame A,5,3(last): slices 2,2,1,1,3,0 then a 48-cycle gap
        first_pending = 1'b1;
        push(4'hA, 1'b0, 1'b1, 1);
        acc0 = acc_cyc;
        push(4'h5, 1'b0, 1'b1, 1);
        push(4'h3, 1'b1, 1'b1, 1);
        idle_in();
        wait_done();
        check("first_slice_latency", first_dv_cyc - acc0, 3);
        check_shape(6, 48, 1);

        // 10M frame 9(last): 1 x10, 2 x10, gap 480; speed change mid-frame ignored
        speed_10m = 1'b1;
        push(4'h9, 1'b1, 1'b1, 10);
        idle_in();
        repeat (5) @(negedge eth_rmii_clk);
        speed_10m = 1'b0;
        wait_done();
        check_shape(20, 480, 1);

        // Underrun: 0x1 without last, late words flushed
        under_cnt = 0;
        push(4'h1, 1'b0, 1'b1, 1);
        idle_in();
        begin
            int w;
            w = 0;
            while (under_cnt == 0 && w < 100) begin @(negedge eth_rmii_clk); w++; end
            check("underrun_seen", int'(under_cnt > 0), 1);
        end
        push(4'h6, 1'b0, 1'b0, 1);
        push(4'h7, 1'b1, 1'b0, 1);
        idle_in();
        wait_done();
        check("underrun_pulses", under_cnt, 1);
        check("underrun_run_count", run_q.size(), 1);
        if (run_q.size() > 0) check("underrun_run_len", run_q.pop_front(), 2);
        check("underrun_gap_count", gap_q.size(), 1);
        if (gap_q.size() > 0) check("underrun_gap_min48", int'(gap_q.pop_front() >= 48), 1);
        check("underrun_drained", exp_q.size(), 0);
        run_q.delete();
        gap_q.delete();

        // Backpressure: 8 words pushed continuously
        saw_not_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] wv;
            wv = 4'(i * 5 + 3);
            push(wv, (i == 7), 1'b1, 1);
        end
        idle_in();
        wait_done();
        check("in_ready_deasserted", int'(saw_not_ready), 1);
        check_shape(16, 48, 1);

        // Back-to-back frames: gap 48 with busy held high
        push(4'hC, 1'b0, 1'b1, 1);
        push(4'h3, 1'b1, 1'b1, 1);
        push(4'h6, 1'b0, 1'b1, 1);
        push(4'h9, 1'b1, 1'b1, 1);
        idle_in();
        wait_done();
        check_shape(4, 48, 2);

        // Reset mid-frame
        speed_10m = 1'b1;
        push(4'hF, 1'b0, 1'b1, 10);
        push(4'hF, 1'b0, 1'b1, 10);
        push(4'hF, 1'b1, 1'b1, 10);
        idle_in();
        begin
            int w;
            w = 0;
            while (!eth_tx_dv && w < 50) begin @(negedge eth_rmii_clk); w++; end
            check("midframe_dv_seen", int'(eth_tx_dv), 1);
        end
        repeat (3) @(negedge eth_rmii_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dv", int'(eth_tx_dv), 0);
        check("async_rst_data", int'(eth_tx_data), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_in_ready", int'(in_ready), 0);
        check("async_rst_underrun", int'(underrun), 0);
        exp_q.delete();
        run_q.delete();
        gap_q.delete();
        repeat (3) @(negedge eth_rmii_clk);
        check("hold_rst_dv", int'(eth_tx_dv), 0);
        speed_10m = 1'b0;
        rst_n = 1'b1;
        cnt_dv   = 0;
        cnt_busy = 0;
        repeat (100) begin
            @(negedge eth_rmii_clk);
            if (eth_tx_dv) cnt_dv++;
            if (busy) cnt_busy++;
        end
        check("post_rst_dv_cycles", cnt_dv, 0);
        check("post_rst_busy_cycles", cnt_busy, 0);
        check("post_rst_in_ready", int'(in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rmii_tx_serializer.md
RMII_TX_SERIALIZER -- requirements
Module: rmii_tx_serializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of eth_rmii_clk.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- IN_W, 4: input word width; multiple of OUT_W; IN_W/OUT_W a power of 2.
- OUT_W, 2: output slice width.
- FIFO_DEPTH, 4: input buffer depth in words; power of 2, at least 2.
- IFG_CYCLES, 48: inter-frame gap in slices.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- eth_rmii_clk, in, 1: clock.
- rst_n, in, 1: async active-low reset.
- speed_10m, in, 1: 1 = hold each slice for 10 clocks, 0 = 1 clock.
- in_valid, in, 1: input word valid.
- in_data, in, IN_W: input word.
- in_last, in, 1: final word of the frame.
- in_ready, out, 1: word accepted when in_valid and in_ready are both high.
- eth_tx_dv, out, 1: transmit enable.
- eth_tx_data, out, OUT_W: transmit slice.
- underrun, out, 1: one-cycle pulse when the FIFO runs dry mid-frame.
- busy, out, 1: high when the state is not IDLE.

Function
REQ-004 Accepted words SHALL be stored as {in_last, in_data} in a FIFO_DEPTH-entry FIFO; in_ready SHALL equal "FIFO not full" and SHALL be derived from registered state only.
REQ-005 A simultaneous push and pop SHALL leave the occupancy unchanged; a push while full SHALL NOT occur, because in_ready is low.
REQ-006 The FSM SHALL have the states IDLE, SEND, FLUSH and IFG.
REQ-007 IDLE -> SEND SHALL occur when the FIFO is non-empty; on this transition the block SHALL pop the first word and latch speed_10m as rep (1 or 10) for the whole frame; changes to speed_10m mid-frame SHALL be ignored.
REQ-008 In SEND, each word SHALL be emitted LSB-first as IN_W/OUT_W slices of OUT_W bits, with each slice held for exactly rep cycles and eth_tx_dv=1.
REQ-009 At the end of the final slice of a word:
- last flag set: go to IFG.
- FIFO non-empty: pop the next word with no gap in eth_tx_dv.
- FIFO empty: pulse underrun for one cycle, drive eth_tx_dv=0 and go to FLUSH.
REQ-010 FLUSH SHALL pop and discard words, keeping in_ready active, until a word with the last flag set is popped, then go to IFG; eth_tx_dv SHALL remain 0 throughout.
REQ-011 IFG SHALL hold eth_tx_dv=0 and eth_tx_data=0 for exactly IFG_CYCLES*rep cycles, then go to IDLE.
REQ-012 eth_tx_dv and eth_tx_data SHALL be registered; eth_tx_data SHALL be 0 whenever eth_tx_dv=0.
REQ-013 Latency: the first slice SHALL appear at the outputs after the second rising edge following the edge that accepts the first word of a frame into an empty FIFO in IDLE.
REQ-014 The slice counter SHALL be log2(IN_W/OUT_W) bits wide and wrap to 0; the rep counter SHALL be 4 bits; the IFG counter SHALL be wide enough to hold IFG_CYCLES*10.

Reset
REQ-015 While rst_n=0 the block SHALL force eth_tx_dv=0, eth_tx_data=0, underrun=0, busy=0 and in_ready=0, empty the FIFO, clear all counters and set the state to IDLE; outputs SHALL go to 0 immediately, mid-frame included.
REQ-016 After rst_n is released, in_ready SHALL rise on the first clock edge; no partial frame SHALL resume.

Structure
REQ-017 The shared package eth_pkg SHALL hold the constants RMII_REP_10M=10 and IFG_DEFAULT=48 and the state enum for IDLE, SEND, FLUSH and IFG.
REQ-018 The FIFO SHALL be a separate sub-module, sync_fifo, with parameters WIDTH and DEPTH and ports wr_en, rd_en, full, empty, din and dout.

Verification
REQ-019 100M, defaults, frame 0xA, 0x5, 0x3(last): eth_tx_dv high for 6 cycles with data 2,2,1,1,3,0, then exactly 48 cycles low.
REQ-020 speed_10m=1, frame 0x9(last): eth_tx_dv high for 20 cycles with data 1 for 10 cycles then 2 for 10; gap 480 cycles.
REQ-021 Underrun: 0x1 pushed without last, then further words arrive late ending with last: data 1,0; eth_tx_dv drops; underrun high for exactly 1 cycle; the late words are discarded with no eth_tx_dv; IFG follows.
REQ-022 Backpressure: a frame of 8 words pushed continuously: in_ready deasserts while the FIFO is full; all 16 slices are output in order with no eth_tx_dv gap.
REQ-023 Back-to-back frames: frame 2 is queued during frame 1: gap between frames exactly 48 cycles; busy stays high across the gap.
REQ-024 rst_n pulsed low mid-frame: all outputs are 0 during reset; after release, FIFO empty and state IDLE with no residual slices.
